// File: rtl/sample_mix_accumulator.sv
// rtl/sample_mix_accumulator.sv - per-voice burst mixer with drain stream
// Voice bursts are written (first voice) or mixed (later voices) into a frame buffer, then streamed out.
module sample_mix_accumulator #(
  parameter int SAMPLE_W = 16,
  parameter int NUM_CH   = 2,
  parameter int DEPTH    = 64,
  parameter int ID_W     = 6,
  parameter int SATURATE = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         stop,
  input  logic                         last_request_sent,
  input  logic [ID_W-1:0]              last_request_id,
  input  logic [NUM_CH*SAMPLE_W-1:0]   in_data,
  input  logic [ID_W-1:0]              in_id,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [NUM_CH*SAMPLE_W-1:0]   out_data,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         batch_done,
  output logic                         len_error,
  output logic [$clog2(DEPTH):0]       frame_count
);

  localparam int FW = NUM_CH * SAMPLE_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  typedef enum logic [2:0] {IDLE, COLLECT_FIRST, COLLECT_ACC, DRAIN, DONE} state_t;

  state_t          state;
  logic [FW-1:0]   mem [DEPTH];
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic            last_seen;
  logic [ID_W-1:0] last_id;

  logic            accept;
  logic            end_of_batch;
  logic            first_wr;
  logic            acc_wr;
  logic            wr_en;
  logic [ID_W-1:0] id_eff;
  logic [AW-1:0]   widx;
  logic [AW-1:0]   ridx;
  logic [FW-1:0]   rmw_data;
  logic [FW-1:0]   wr_data;

  // Per-channel signed add; one guard bit is enough to detect overflow of a two-operand sum.
  function automatic logic [FW-1:0] mix(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [FW-1:0]             r;
    logic signed [SAMPLE_W:0]  s;
    logic signed [SAMPLE_W:0]  max_v;
    logic signed [SAMPLE_W:0]  min_v;
    r     = '0;
    max_v = {2'b00, {(SAMPLE_W-1){1'b1}}};
    min_v = {2'b11, {(SAMPLE_W-1){1'b0}}};
    for (int c = 0; c < NUM_CH; c++) begin
      s = signed'({a[c*SAMPLE_W+SAMPLE_W-1], a[c*SAMPLE_W +: SAMPLE_W]})
        + signed'({b[c*SAMPLE_W+SAMPLE_W-1], b[c*SAMPLE_W +: SAMPLE_W]});
      if (SATURATE != 0 && s > max_v)
        r[c*SAMPLE_W +: SAMPLE_W] = max_v[SAMPLE_W-1:0];
      else if (SATURATE != 0 && s < min_v)
        r[c*SAMPLE_W +: SAMPLE_W] = min_v[SAMPLE_W-1:0];
      else
        r[c*SAMPLE_W +: SAMPLE_W] = s[SAMPLE_W-1:0];
    end
    return r;
  endfunction

  assign in_ready     = (state == COLLECT_FIRST) || (state == COLLECT_ACC);
  assign accept       = in_valid && in_ready;
  // A final request issued in the same cycle as the burst's last beat still ends the batch.
  assign id_eff       = last_request_sent ? last_request_id : last_id;
  assign end_of_batch = accept && in_last && (in_id == id_eff) && (last_seen || last_request_sent);

  assign widx     = wptr[AW-1:0];
  assign ridx     = rptr[AW-1:0];
  assign first_wr = (state == COLLECT_FIRST) && accept && (wptr != DEPTH_V);
  assign acc_wr   = (state == COLLECT_ACC) && accept && (wptr < frame_count);
  assign wr_en    = (first_wr || acc_wr) && !stop;
  assign rmw_data = mix(mem[widx], in_data);
  assign wr_data  = first_wr ? in_data : rmw_data;

  assign out_data = mem[ridx];
  assign out_last = (state == DRAIN) && (rptr == frame_count - ONE);

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[widx] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      frame_count <= '0;
      last_seen   <= 1'b0;
      last_id     <= '0;
      out_valid   <= 1'b0;
      batch_done  <= 1'b0;
      len_error   <= 1'b0;
    end else if (stop) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      frame_count <= '0;
      last_seen   <= 1'b0;
      out_valid   <= 1'b0;
      batch_done  <= 1'b0;
      len_error   <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      if (last_request_sent) begin
        last_seen <= 1'b1;
        last_id   <= last_request_id;
      end
      case (state)
        IDLE: begin
          if (enable)
            state <= COLLECT_FIRST;
        end
        COLLECT_FIRST: begin
          if (accept) begin
            if (wptr != DEPTH_V)
              wptr <= wptr + ONE;
            else
              len_error <= 1'b1;
            if (in_last) begin
              frame_count <= (wptr != DEPTH_V) ? wptr + ONE : wptr;
              wptr        <= '0;
              if (end_of_batch) begin
                state     <= DRAIN;
                rptr      <= '0;
                out_valid <= 1'b1;
              end else begin
                state <= COLLECT_ACC;
              end
            end
          end
        end
        COLLECT_ACC: begin
          if (accept) begin
            if (wptr < frame_count)
              wptr <= wptr + ONE;
            else
              len_error <= 1'b1;
            if (in_last) begin
              if (wptr + ONE != frame_count)
                len_error <= 1'b1;
              wptr <= '0;
              if (end_of_batch) begin
                state     <= DRAIN;
                rptr      <= '0;
                out_valid <= 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state      <= DONE;
              out_valid  <= 1'b0;
              rptr       <= '0;
              batch_done <= 1'b1;
              last_seen  <= 1'b0;
            end else begin
              rptr <= rptr + ONE;
            end
          end
        end
        DONE: begin
          len_error   <= 1'b0;
          frame_count <= '0;
          last_seen   <= 1'b0;
          state       <= enable ? COLLECT_FIRST : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_mix_accumulator.sv
// tb/tb_sample_mix_accumulator.sv - directed bench for sample_mix_accumulator
// Saturating and wrapping instances share all inputs; only their mixed data differs.
module tb_sample_mix_accumulator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        stop = 1'b0;
  logic        last_request_sent = 1'b0;
  logic [5:0]  last_request_id = '0;
  logic [31:0] in_data = '0;
  logic [5:0]  in_id = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_last, batch_done, len_error;
  logic [31:0] out_data;
  logic [6:0]  frame_count;
  logic        in_ready_w, out_valid_w, out_last_w, batch_done_w, len_error_w;
  logic [31:0] out_data_w;
  logic [6:0]  frame_count_w;

  sample_mix_accumulator #(.SATURATE(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .stop(stop),
    .last_request_sent(last_request_sent), .last_request_id(last_request_id),
    .in_data(in_data), .in_id(in_id), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .batch_done(batch_done), .len_error(len_error),
    .frame_count(frame_count)
  );

  sample_mix_accumulator #(.SATURATE(0)) dut_w (
    .clk(clk), .reset_n(reset_n), .enable(enable), .stop(stop),
    .last_request_sent(last_request_sent), .last_request_id(last_request_id),
    .in_data(in_data), .in_id(in_id), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_w), .out_data(out_data_w), .out_valid(out_valid_w), .out_last(out_last_w),
    .out_ready(out_ready), .batch_done(batch_done_w), .len_error(len_error_w),
    .frame_count(frame_count_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_sat;
    logic [31:0] exp_wrap;
  } mix_vec_t;

  mix_vec_t    mix_tab[6];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] beats[80];
  logic [31:0] got_s[80];
  logic [31:0] got_w[80];
  bit          got_l[80];
  int          got_n, stall_bad, inready_bad;
  bit          rdy_pat[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_burst(input logic [5:0] id, input int n, input int lrs_beat, input logic [5:0] lrs_id);
    for (int i = 0; i < n; i++) begin
      in_valid          = 1'b1;
      in_data           = beats[i];
      in_id             = id;
      in_last           = (i == n - 1);
      last_request_sent = (i == lrs_beat);
      last_request_id   = lrs_id;
      @(posedge clk); #1;
    end
    in_valid          = 1'b0;
    in_last           = 1'b0;
    last_request_sent = 1'b0;
  endtask

  task automatic drain(input bit use_pat);
    bit          stalled;
    bit          done;
    logic [31:0] held;
    got_n = 0; stall_bad = 0; inready_bad = 0;
    stalled = 0; done = 0; held = '0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      out_ready = use_pat ? rdy_pat[cyc % 4] : 1'b1;
      if (in_ready) inready_bad++;
      if (stalled && out_data !== held) stall_bad++;
      stalled = 0;
      if (out_valid && out_ready) begin
        if (got_n < 80) begin
          got_s[got_n] = out_data;
          got_w[got_n] = out_data_w;
          got_l[got_n] = out_last;
        end
        got_n++;
        if (out_last) done = 1;
      end else if (out_valid) begin
        stalled = 1;
        held    = out_data;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d frames, no out_last handshake", got_n);
    end
  endtask

  initial begin
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    mix_tab[0] = '{32'h0003_7000, 32'h0001_2000, 32'h0004_7FFF, 32'h0004_9000};
    mix_tab[1] = '{32'h0000_9000, 32'h0000_A000, 32'h0000_8000, 32'h0000_3000};
    mix_tab[2] = '{32'h7FFF_0001, 32'h0001_FFFF, 32'h7FFF_0000, 32'h8000_0000};
    mix_tab[3] = '{32'h1234_FFFE, 32'h1111_FFFD, 32'h2345_FFFB, 32'h2345_FFFB};
    mix_tab[4] = '{32'h8000_4000, 32'hFFFF_4000, 32'h8000_7FFF, 32'h7FFF_8000};
    mix_tab[5] = '{32'h0005_0006, 32'h0000_0000, 32'h0005_0006, 32'h0005_0006};

    repeat (2) @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_batch_done", batch_done, 0);
    check("rst_len_error", len_error, 0);
    check("rst_frame_count", frame_count, 0);

    reset_n = 1'b1;
    enable  = 1'b1;
    @(posedge clk); #1;
    check("collect_in_ready", in_ready, 1);

    // single voice passes through unchanged
    beats[0] = 32'h0001_0002; beats[1] = 32'h0002_0003;
    beats[2] = 32'h0003_0004; beats[3] = 32'h0004_0005;
    send_burst(6'd3, 4, 1, 6'd3);
    check("t1_latency_valid", out_valid, 1);
    check("t1_frame_count", frame_count, 4);
    drain(0);
    check("t1_frames", got_n, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_data%0d", i), got_s[i], beats[i]);
      check($sformatf("t1_last%0d", i), got_l[i], (i == 3));
    end
    check("t1_batch_done", batch_done, 1);
    @(posedge clk); #1;
    check("t1_batch_done_pulse", batch_done, 0);
    check("t1_frame_count_clr", frame_count, 0);
    check("t1_recollect", in_ready, 1);

    // two voices mixed, saturating and wrapping instances side by side
    for (int i = 0; i < 6; i++) beats[i] = mix_tab[i].a;
    send_burst(6'd1, 6, 2, 6'd2);
    for (int i = 0; i < 6; i++) beats[i] = mix_tab[i].b;
    send_burst(6'd2, 6, -1, 6'd0);
    check("t2_valid", out_valid, 1);
    check("t2_len_error", len_error, 0);
    check("t2_frame_count", frame_count, 6);
    drain(0);
    check("t2_frames", got_n, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_sat%0d", i), got_s[i], mix_tab[i].exp_sat);
      check($sformatf("t2_wrap%0d", i), got_w[i], mix_tab[i].exp_wrap);
    end
    @(posedge clk); #1;

    // length mismatch plus output backpressure
    for (int i = 0; i < 6; i++) beats[i] = 32'h0001_0010 + 32'(i);
    send_burst(6'd1, 4, 0, 6'd2);
    for (int i = 0; i < 6; i++) beats[i] = 32'h0100_1000 + 32'(i);
    send_burst(6'd2, 6, -1, 6'd0);
    check("t3_len_error", len_error, 1);
    check("t3_frame_count", frame_count, 4);
    drain(1);
    check("t3_frames", got_n, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_data%0d", i), got_s[i], 32'h0101_1020 + 32'(2 * i) - 32'h10);
    check("t3_last3", got_l[3], 1);
    check("t3_last0", got_l[0], 0);
    check("t3_stall_stable", stall_bad, 0);
    check("t3_in_ready_drain", inready_bad, 0);
    check("t3_batch_done", batch_done, 1);
    @(posedge clk); #1;
    check("t3_len_error_clr", len_error, 0);

    // final request arrives with the last beat
    beats[0] = 32'h0000_0A00; beats[1] = 32'h0000_0A01;
    send_burst(6'd5, 2, 1, 6'd5);
    check("t4_same_cycle_valid", out_valid, 1);
    drain(0);
    check("t4_same_frames", got_n, 2);
    check("t4_same_data1", got_s[1], 32'h0000_0A01);
    @(posedge clk); #1;

    // final request one cycle late: wait for next id-5 burst
    for (int i = 0; i < 3; i++) beats[i] = 32'h0000_0001 + 32'(i);
    send_burst(6'd5, 3, -1, 6'd0);
    last_request_sent = 1'b1;
    last_request_id   = 6'd5;
    @(posedge clk); #1;
    last_request_sent = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("t4_late_no_drain", out_valid, 0);
    check("t4_late_collecting", in_ready, 1);
    for (int i = 0; i < 3; i++) beats[i] = 32'h0000_0010 + 32'(i);
    send_burst(6'd5, 3, -1, 6'd0);
    check("t4_late_valid", out_valid, 1);
    drain(0);
    check("t4_late_frames", got_n, 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t4_late_data%0d", i), got_s[i], 32'h0000_0011 + 32'(2 * i));
    @(posedge clk); #1;

    // stop while accumulating, then a clean batch
    beats[0] = 32'h1000_1000; beats[1] = 32'h1000_1001;
    send_burst(6'd1, 2, -1, 6'd0);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("t5_stop_acc_idle", in_ready, 0);
    check("t5_stop_acc_valid", out_valid, 0);
    check("t5_stop_acc_fc", frame_count, 0);
    @(posedge clk); #1;
    check("t5_restart", in_ready, 1);
    beats[0] = 32'h0000_0007; beats[1] = 32'h0000_0008;
    send_burst(6'd4, 2, 1, 6'd4);
    drain(0);
    check("t5_clean_frames", got_n, 2);
    check("t5_clean_data0", got_s[0], 32'h0000_0007);
    check("t5_clean_data1", got_s[1], 32'h0000_0008);
    @(posedge clk); #1;

    // stop while draining
    for (int i = 0; i < 3; i++) beats[i] = 32'h0000_0100 + 32'(i);
    send_burst(6'd6, 3, 0, 6'd6);
    check("t5_drain_valid", out_valid, 1);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("t5_stop_drain_valid", out_valid, 0);
    check("t5_stop_drain_done", batch_done, 0);
    @(posedge clk); #1;
    check("t5_stop_drain_done2", batch_done, 0);
    beats[0] = 32'h0000_0042;
    send_burst(6'd7, 1, 0, 6'd7);
    check("t5_single_fc", frame_count, 1);
    drain(0);
    check("t5_single_frames", got_n, 1);
    check("t5_single_data", got_s[0], 32'h0000_0042);
    check("t5_single_last", got_l[0], 1);
    @(posedge clk); #1;

    // burst one beat longer than the buffer
    for (int i = 0; i < 65; i++) beats[i] = 32'(i);
    send_burst(6'd9, 65, 0, 6'd9);
    check("t6_frame_count", frame_count, 64);
    check("t6_len_error", len_error, 1);
    drain(0);
    check("t6_frames", got_n, 64);
    check("t6_data0", got_s[0], 32'h0);
    check("t6_data63", got_s[63], 32'd63);
    check("t6_last63", got_l[63], 1);
    check("t6_batch_done", batch_done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_mix_accumulator.md
Name: sample_mix_accumulator

Overview:
Parametrised successor to the DMA sample receiver. Accepts per-voice sample bursts from the AXI bridge and mixes them into an internal multi-channel accumulator buffer, using signed saturating or wrapping adds. Once the last requested voice of a batch has arrived, it drains the mixed frames to the output FIFO over a valid/ready stream. It sits between the AXI bridge/DMA requester and the playback output FIFO.

Parameters:
SAMPLE_W, 16, bits per channel sample (signed two's complement)
NUM_CH, 2, channels per frame; frame = NUM_CH*SAMPLE_W bits, ch0 in LSBs
DEPTH, 64, max frames per burst (power of 2, >=2)
ID_W, 6, voice/request ID width
SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^SAMPLE_W

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  start collecting batches when high
stop  in  1  synchronous abort to IDLE, clears buffer state
last_request_sent  in  1  pulse: requester issued final request of batch
last_request_id  in  ID_W  ID of that final request
in_data  in  NUM_CH*SAMPLE_W  burst beat (one frame)
in_id  in  ID_W  voice ID of beat
in_valid  in  1  beat valid
in_last  in  1  final beat of the voice burst
in_ready  out  1  beat accepted when in_valid&&in_ready
out_data  out  NUM_CH*SAMPLE_W  mixed frame
out_valid  out  1  mixed frame available
out_last  out  1  final frame of batch
out_ready  in  1  consumer accepts frame
batch_done  out  1  one-cycle pulse, batch fully drained
len_error  out  1  sticky: burst length mismatch/overflow in batch
frame_count  out  log2(DEPTH)+1  frames in current batch

Behaviour:
- Reset: state IDLE; in_ready, out_valid, out_last, batch_done, len_error = 0; frame_count = 0; pointers = 0; last_seen = 0. Buffer contents are don't-care.
- States: IDLE, COLLECT_FIRST, COLLECT_ACC, DRAIN, DONE.
- stop has priority in every state: next state is IDLE, pointers, last_seen and frame_count clear, and out_valid = 0 from the next cycle.
- IDLE -> COLLECT_FIRST when enable && !stop.
- in_ready = 1 only in COLLECT_FIRST and COLLECT_ACC.
- COLLECT_FIRST: each accepted beat writes buf[wptr] = in_data and increments wptr. Beats with wptr == DEPTH are dropped and set len_error. On an accepted in_last: frame_count = beats written, wptr = 0, go to COLLECT_ACC unless the end-of-batch condition holds.
- COLLECT_ACC: each accepted beat does buf[wptr] = sat_add(buf[wptr], in_data) per channel, with a single-cycle read-modify-write (combinational read). Beats with wptr >= frame_count are dropped and set len_error. On in_last with wptr+1 != frame_count, set len_error. wptr = 0 on in_last.
- sat_add (SATURATE=1): signed sum clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. With SATURATE=0, truncate to SAMPLE_W bits.
- last_seen: set by last_request_sent, which also latches last_request_id into last_id; cleared on entering DONE or IDLE.
- End-of-batch: an accepted beat with in_last && in_id == id_eff && (last_seen || last_request_sent). id_eff = last_request_id when last_request_sent is high that cycle, else last_id. On this condition go to DRAIN next cycle. If last_request_sent arrives after the last burst, the batch does not end; the FSM waits for the next matching burst.
- DRAIN: rptr starts at 0. out_data = buf[rptr]; out_valid = 1; out_last = (rptr == frame_count-1). out_data must stay stable while out_valid && !out_ready. Each handshake increments rptr. The handshake on out_last goes to DONE.
- DONE: batch_done = 1 for exactly one cycle. len_error and frame_count clear, then go to COLLECT_FIRST if enable, else IDLE.
- Latency: first out_valid is asserted 1 cycle after the end-of-batch beat. With out_ready held high, throughput is 1 frame/cycle.
- len_error stays visible until DONE or stop.

Test Plan:
- Single voice, SAMPLE_W=16, NUM_CH=2: id 3 sends 4 beats 0x0001_0002..0x0004_0005 with last_request_sent/id=3 on beat 1 -> 4 out frames identical to input, out_last on 4th, batch_done pulse 1 cycle after.
- Two voices, saturation: voice0 ch0 = 0x7000, voice1 ch0 = 0x2000 -> out ch0 = 0x7FFF. Negative case: 0x9000 + 0xA000 -> 0x8000. With SATURATE=0, 0x7000 + 0x2000 -> 0x9000.
- Length mismatch: voice0 sends 4 beats, voice1 sends 6 beats -> beats 5 and 6 dropped, len_error = 1, drain of 4 frames, len_error cleared after DONE.
- Backpressure: out_ready toggled 1-0-0-1 during drain -> out_data stable while stalled, no frame lost or duplicated, in_ready = 0 throughout DRAIN.
- Late last_request: last_request_sent/id=5 asserted in the same cycle as the in_last beat of id 5 -> DRAIN entered next cycle. If it is asserted one cycle after that beat -> no drain until the next id-5 burst.
- stop mid-COLLECT_ACC and mid-DRAIN -> IDLE next cycle, out_valid = 0, no batch_done. A subsequent batch mixes from a clean buffer (first voice written, not accumulated).
